// File: rtl/benes_stage_pipe.sv
// One column of SIZE/2 2x2 crossbar switches behind a valid/ready register slice,
// with shadow/active switch settings. Define BENES_STAGE_SKID_EN for a 2-entry skid FIFO output.
module benes_stage_pipe #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_shadow_wr,
  input  logic [SIZE/2-1:0]    cfg_shadow_data,
  input  logic                 cfg_commit,
  output logic [SIZE/2-1:0]    cfg_active,
  output logic                 cfg_pending,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data  [0:SIZE-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data [0:SIZE-1]
);

  localparam int SWITCH_NUM = SIZE / 2;

  // Handshake: a beat moves on in when in_valid && in_ready, and out when
  // out_valid && out_ready; both are sampled on the same rising clock edge.
  logic                  accept;
  logic [SWITCH_NUM-1:0] shadow_q;
  logic [WIDTH-1:0]      perm [0:SIZE-1];

  assign accept = in_valid && in_ready;

  // Same-cycle write and commit writes straight through to the active config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      cfg_active  <= '0;
      cfg_pending <= 1'b0;
    end else if (cfg_shadow_wr && cfg_commit) begin
      shadow_q    <= cfg_shadow_data;
      cfg_active  <= cfg_shadow_data;
      cfg_pending <= 1'b0;
    end else if (cfg_shadow_wr) begin
      shadow_q    <= cfg_shadow_data;
      cfg_pending <= 1'b1;
    end else if (cfg_commit) begin
      cfg_active  <= shadow_q;
      cfg_pending <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < SWITCH_NUM; k++) begin
      perm[2*k]   = cfg_active[k] ? in_data[2*k+1] : in_data[2*k];
      perm[2*k+1] = cfg_active[k] ? in_data[2*k]   : in_data[2*k+1];
    end
  end

`ifdef BENES_STAGE_SKID_EN
  logic             xfer;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] mem [0:1][0:SIZE-1];

  assign xfer      = out_valid && out_ready;
  // in_ready depends only on registered occupancy, cutting the out_ready path.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int e = 0; e < 2; e++)
        for (int i = 0; i < SIZE; i++)
          mem[e][i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= perm;
        wr_ptr      <= ~wr_ptr;
      end
      if (xfer)
        rd_ptr <= ~rd_ptr;
      case ({accept, xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int i = 0; i < SIZE; i++)
        out_data[i] <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= perm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_benes_stage_pipe.sv
// Directed bench for benes_stage_pipe: reset, switching, config timing, stalls,
// async reset mid-stall and (with BENES_STAGE_SKID_EN) skid behaviour.
module tb_benes_stage_pipe;
  localparam int SIZE  = 32;
  localparam int WIDTH = 8;
  localparam int SN    = SIZE / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_shadow_wr;
  logic [SN-1:0]    cfg_shadow_data;
  logic             cfg_commit;
  logic [SN-1:0]    cfg_active;
  logic             cfg_pending;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data  [0:SIZE-1];
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data [0:SIZE-1];

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  benes_stage_pipe #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_shadow_wr(cfg_shadow_wr), .cfg_shadow_data(cfg_shadow_data),
    .cfg_commit(cfg_commit), .cfg_active(cfg_active), .cfg_pending(cfg_pending),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [WIDTH-1:0] base);
    for (int i = 0; i < SIZE; i++) in_data[i] = base + WIDTH'(i);
  endtask

  task automatic write_through(input logic [SN-1:0] v);
    cfg_shadow_data = v;
    cfg_shadow_wr   = 1'b1;
    cfg_commit      = 1'b1;
    step();
    cfg_shadow_wr   = 1'b0;
    cfg_commit      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    cfg_shadow_wr = 1'b0; cfg_shadow_data = '0; cfg_commit = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    drive_beat(8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_tests++; if (cfg_active !== '0) begin n_fail++; $display("FAIL reset_cfg_active got %h exp 0", cfg_active); end
    n_tests++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_pending got %b exp 0", cfg_pending); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== '0 && bad < 0) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL reset_out_data idx %0d got %h exp 0", bad, out_data[bad]); end
    step();
  endtask

  task automatic test_straight();
    int bad;
    drive_beat(8'h00); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL straight_valid got %b exp 1", out_valid); end
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== WIDTH'(i) && bad < 0) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL straight_data idx %0d got %h exp %h", bad, out_data[bad], WIDTH'(bad)); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL straight_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_cross_commit();
    int bad;
    cfg_shadow_data = 16'hFFFF; cfg_shadow_wr = 1'b1;
    step();
    cfg_shadow_wr = 1'b0;
    n_tests++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL cross_pending_set got %b exp 1", cfg_pending); end
    n_tests++; if (cfg_active !== 16'h0000) begin n_fail++; $display("FAIL cross_active_before got %h exp 0000", cfg_active); end
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    n_tests++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL cross_pending_clr got %b exp 0", cfg_pending); end
    n_tests++; if (cfg_active !== 16'hFFFF) begin n_fail++; $display("FAIL cross_active got %h exp ffff", cfg_active); end
    drive_beat(8'h00); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== WIDTH'(i ^ 1) && bad < 0) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL cross_data idx %0d got %h exp %h", bad, out_data[bad], WIDTH'(bad ^ 1)); end
    step();
  endtask

  task automatic test_commit_timing();
    int bad;
    write_through(16'h0000);
    cfg_shadow_data = 16'hFFFF; cfg_shadow_wr = 1'b1;
    step();
    cfg_shadow_wr = 1'b0;
    cfg_commit = 1'b1; drive_beat(8'h40); in_valid = 1'b1;
    step();
    cfg_commit = 1'b0; drive_beat(8'h80);
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== 8'h40 + WIDTH'(i) && bad < 0) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL commit_cycle_beat idx %0d got %h exp %h", bad, out_data[bad], 8'h40 + WIDTH'(bad)); end
    step();
    in_valid = 1'b0;
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== 8'h80 + WIDTH'(i ^ 1) && bad < 0) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL post_commit_beat idx %0d got %h exp %h", bad, out_data[bad], 8'h80 + WIDTH'(bad ^ 1)); end
    step();
  endtask

  task automatic test_write_through();
    int bad;
    write_through(16'h0001);
    n_tests++; if (cfg_active !== 16'h0001) begin n_fail++; $display("FAIL wt_active got %h exp 0001", cfg_active); end
    n_tests++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL wt_pending got %b exp 0", cfg_pending); end
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    n_tests++; if (cfg_active !== 16'h0001) begin n_fail++; $display("FAIL recommit_active got %h exp 0001", cfg_active); end
    drive_beat(8'h00); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    bad = -1;
    for (int i = 0; i < SIZE; i++)
      if (out_data[i] !== ((i < 2) ? WIDTH'(i ^ 1) : WIDTH'(i)) && bad < 0) bad = i;
    n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL wt_data idx %0d got %h", bad, out_data[bad]); end
    step();
  endtask

  task automatic test_stall_stream();
    int sent, recv, stall_seen, bad;
    logic [WIDTH-1:0] e;
    write_through(16'h0000);
    exp_q.delete();
    sent = 0; recv = 0; stall_seen = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 8) begin in_valid = 1'b1; drive_beat(WIDTH'(sent * 32)); end
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready && exp_q.size() > 0) begin
        stall_seen++;
`ifndef BENES_STAGE_SKID_EN
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc %0d got %b exp 0", c, in_ready); end
`endif
        bad = -1;
        for (int i = 0; i < SIZE; i++) if (out_data[i] !== exp_q[0] + WIDTH'(i) && bad < 0) bad = i;
        n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL stall_hold cyc %0d idx %0d got %h", c, bad, out_data[bad]); end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra cyc %0d got beat %h exp none", c, out_data[0]);
        end else begin
          e = exp_q.pop_front();
          bad = -1;
          for (int i = 0; i < SIZE; i++) if (out_data[i] !== e + WIDTH'(i) && bad < 0) bad = i;
          if (bad >= 0) begin n_fail++; $display("FAIL stream_data beat %0d idx %0d got %h exp %h", recv, bad, out_data[bad], e + WIDTH'(bad)); end
        end
        recv++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(WIDTH'(sent * 32)); sent++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++; if (recv !== 8 || exp_q.size() !== 0) begin n_fail++; $display("FAIL stream_count got %0d exp 8", recv); end
    n_tests++; if (stall_seen !== 3) begin n_fail++; $display("FAIL stream_stall_cycles got %0d exp 3", stall_seen); end
    step();
  endtask

`ifdef BENES_STAGE_SKID_EN
  task automatic test_skid();
    int bad;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      drive_beat(WIDTH'(b * 32));
      #1;
      n_tests++; if (in_ready !== (b < 2)) begin n_fail++; $display("FAIL skid_fill_ready beat %0d got %b exp %b", b, in_ready, b < 2); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_no_comb_ready got %b exp 0", in_ready); end
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== WIDTH'(i) && bad < 0) bad = i;
    n_tests++; if (out_valid !== 1'b1 || bad >= 0) begin n_fail++; $display("FAIL skid_head valid %b got %h exp %h", out_valid, out_data[0], 8'h00); end
    step();
    for (int b = 2; b < 7; b++) begin
      drive_beat(WIDTH'(b * 32));
      #1;
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL skid_flow beat %0d ready %b valid %b exp 1 1", b, in_ready, out_valid); end
      bad = -1;
      for (int i = 0; i < SIZE; i++) if (out_data[i] !== WIDTH'((b - 1) * 32 + i) && bad < 0) bad = i;
      n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL skid_order beat %0d idx %0d got %h exp %h", b - 1, bad, out_data[bad], WIDTH'((b - 1) * 32 + bad)); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_data[0] !== 8'hC0) begin n_fail++; $display("FAIL skid_last valid %b got %h exp c0", out_valid, out_data[0]); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_empty got %b exp 0", out_valid); end
  endtask
`endif

  task automatic test_reset_mid_stall();
    int bad;
    write_through(16'h0001);
    out_ready = 1'b0; drive_beat(8'h20); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b exp 0", out_valid); end
    n_tests++; if (cfg_active !== '0) begin n_fail++; $display("FAIL rst_async_cfg got %h exp 0", cfg_active); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    step();
    drive_beat(8'h40); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    bad = -1;
    for (int i = 0; i < SIZE; i++) if (out_data[i] !== 8'h40 + WIDTH'(i) && bad < 0) bad = i;
    n_tests++; if (out_valid !== 1'b1 || bad >= 0) begin n_fail++; $display("FAIL rst_first_beat valid %b got %h exp %h", out_valid, out_data[0], 8'h40); end
    step();
  endtask

  initial begin
    test_reset();
    test_straight();
    test_cross_commit();
    test_commit_timing();
    test_write_through();
    test_stall_stream();
`ifdef BENES_STAGE_SKID_EN
    test_skid();
`endif
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
